// File: rtl/cpu_mem_pkg.sv
// Size encodings shared between the pipeline, the store buffer and the data memory,
// plus the buffered-store entry type.
package cpu_mem_pkg;

  localparam logic [1:0] WcWord = 2'b00;
  localparam logic [1:0] WcHalf = 2'b01;
  localparam logic [1:0] WcByte = 2'b10;

  localparam logic [2:0] RcLb  = 3'b000;
  localparam logic [2:0] RcLbu = 3'b001;
  localparam logic [2:0] RcLh  = 3'b010;
  localparam logic [2:0] RcLhu = 3'b011;
  localparam logic [2:0] RcLw  = 3'b100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ModeIdle,
    ModeLoad,
    ModeDrain
  } sb_mode_e;

  // 2'b11 is treated as a word store.
  function automatic logic [2:0] st_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      WcHalf:  n = 3'd2;
      WcByte:  n = 3'd1;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] ld_bytes(input logic [2:0] size);
    logic [2:0] n;
    case (size)
      RcLb, RcLbu: n = 3'd1;
      RcLh, RcLhu: n = 3'd2;
      default:     n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sb_overlap.sv
// Byte-range overlap test between one buffered store and the current load.
// Ranges are half-open and widened to 33 bits so an access crossing 2^32 never aliases low memory.
module sb_overlap
  import cpu_mem_pkg::*;
(
  input  logic        entry_valid_i,
  input  logic [31:0] entry_addr_i,
  input  logic [1:0]  entry_size_i,
  input  logic [31:0] ld_addr_i,
  input  logic [2:0]  ld_size_i,
  output logic        hit_o
);

  logic [32:0] st_lo, st_hi, ld_lo, ld_hi;

  assign st_lo = {1'b0, entry_addr_i};
  assign st_hi = st_lo + {30'b0, st_bytes(entry_size_i)};
  assign ld_lo = {1'b0, ld_addr_i};
  assign ld_hi = ld_lo + {30'b0, ld_bytes(ld_size_i)};

  assign hit_o = entry_valid_i && (ld_lo < st_hi) && (st_lo < ld_hi);

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between the MEM stage and a single-ported data memory.
// Loads take the port when they do not overlap a buffered store; otherwise the head store drains.
module store_buffer
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_stall,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_writecontrol,
  output logic [2:0]  mem_readcontrol,
  output logic        empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  sb_entry_t       entries_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic             full, push, pop, conflict;
  logic [DEPTH-1:0] entry_valid, hit;
  sb_mode_e         mode;
  sb_entry_t        head_entry;

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign st_ready   = !full;
  assign head_entry = entries_q[head_q];

  // An entry is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PtrW-1:0] off;
    assign off            = PtrW'(i) - head_q;
    assign entry_valid[i] = CntW'(off) < count_q;

    sb_overlap u_overlap (
      .entry_valid_i(entry_valid[i]),
      .entry_addr_i (entries_q[i].addr),
      .entry_size_i (entries_q[i].size),
      .ld_addr_i    (ld_addr),
      .ld_size_i    (ld_size),
      .hit_o        (hit[i])
    );
  end

  assign conflict = ld_valid && (|hit);
  assign ld_stall = ld_valid && (conflict || full);

  always_comb begin
    if (ld_valid && !conflict && !full) begin
      mode = ModeLoad;
    end else if (!empty) begin
      mode = ModeDrain;
    end else begin
      mode = ModeIdle;
    end
  end

  assign push = st_valid && st_ready;
  assign pop  = (mode == ModeDrain);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mem_we           = 1'b0;
    mem_a            = '0;
    mem_wd           = '0;
    mem_writecontrol = WcWord;
    mem_readcontrol  = RcLw;
    unique case (mode)
      ModeLoad: begin
        mem_a           = ld_addr;
        mem_readcontrol = ld_size;
      end
      ModeDrain: begin
        mem_we           = 1'b1;
        mem_a            = head_entry.addr;
        mem_wd           = head_entry.data;
        mem_writecontrol = head_entry.size;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= '{addr: st_addr, data: st_data, size: st_size};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer: a queue-based model is compared every cycle,
// and directed sequences pin the model with hand-computed values.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic        ld_stall;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [1:0]  mem_writecontrol;
  logic [2:0]  mem_readcontrol;
  logic        empty;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_size         (st_size),
    .st_ready        (st_ready),
    .ld_valid        (ld_valid),
    .ld_addr         (ld_addr),
    .ld_size         (ld_size),
    .ld_stall        (ld_stall),
    .mem_we          (mem_we),
    .mem_a           (mem_a),
    .mem_wd          (mem_wd),
    .mem_writecontrol(mem_writecontrol),
    .mem_readcontrol (mem_readcontrol),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } ent_t;

  ent_t mq[$];

  function automatic int st_n(input logic [1:0] s);
    if (s == 2'b01) return 2;
    if (s == 2'b10) return 1;
    return 4;
  endfunction

  function automatic int ld_n(input logic [2:0] s);
    if (s == 3'b000 || s == 3'b001) return 1;
    if (s == 3'b010 || s == 3'b011) return 2;
    return 4;
  endfunction

  // Byte-by-byte overlap on unbounded addresses.
  function automatic bit m_conflict();
    longint la, sa;
    if (!ld_valid) return 0;
    la = longint'({32'h0, ld_addr});
    foreach (mq[i]) begin
      sa = longint'({32'h0, mq[i].addr});
      for (int j = 0; j < ld_n(ld_size); j++)
        for (int k = 0; k < st_n(mq[i].size); k++)
          if (la + j == sa + k) return 1;
    end
    return 0;
  endfunction

  // 0 idle, 1 load, 2 drain
  function automatic int m_mode();
    if (ld_valid && !m_conflict() && mq.size() != DEPTH) return 1;
    if (mq.size() != 0) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit do_push;
      ent_t e;
      do_push = st_valid && (mq.size() != DEPTH);
      e.addr = st_addr;
      e.data = st_data;
      e.size = st_size;
      if (m_mode() == 2) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    int n;
    int md;
    bit conf;
    n    = mq.size();
    md   = m_mode();
    conf = m_conflict();
    chk("st_ready", st_ready, 32'(n != DEPTH));
    chk("empty", empty, 32'(n == 0));
    chk("ld_stall", ld_stall, 32'(ld_valid && (conf || n == DEPTH)));
    chk("mem_we", mem_we, 32'(md == 2));
    if (md == 2) begin
      chk("drain_a", mem_a, mq[0].addr);
      chk("drain_wd", mem_wd, mq[0].data);
      chk("drain_wc", 32'(mem_writecontrol), 32'(mq[0].size));
    end else if (md == 1) begin
      chk("load_a", mem_a, ld_addr);
      chk("load_rc", 32'(mem_readcontrol), 32'(ld_size));
    end else begin
      chk("idle_a", mem_a, 32'h0);
      chk("idle_rc", 32'(mem_readcontrol), 32'h4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic drv_ld(input logic v, input logic [31:0] a, input logic [2:0] s);
    ld_valid = v;
    ld_addr  = a;
    ld_size  = s;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 15));
    return 32'h20 + 32'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b1;
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    drv_ld(1'b0, 32'h0, 3'b100);
    tick();
    drv_st(1'b1, 32'h10, 32'h1, 2'b00);
    #1;
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_we", mem_we, 0);
    tick();
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    #1 reset = 1'b0;
    tick();

    // Single word store reaches memory one cycle later.
    drv_st(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b00);
    #1;
    chk("r36_nobypass", mem_we, 0);
    tick();
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("r36_we", mem_we, 1);
    chk("r36_a", mem_a, 32'h10);
    chk("r36_wd", mem_wd, 32'hDEAD_BEEF);
    tick();
    chk("r36_empty", empty, 1);

    // Fill behind a held non-conflicting load, then full push+pop.
    drv_ld(1'b1, 32'h100, 3'b100);
    for (int k = 0; k < 4; k++) begin
      drv_st(1'b1, 32'h40 + 32'(4 * k), 32'hA0 + 32'(k), 2'b00);
      tick();
    end
    drv_st(1'b1, 32'h50, 32'hBAD, 2'b00);
    #1;
    chk("r37_ready", st_ready, 0);
    chk("r37_stall", ld_stall, 1);
    chk("r37_we", mem_we, 1);
    chk("r37_a", mem_a, 32'h40);
    tick();
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("r40_ready", st_ready, 1);
    chk("r40_stall", ld_stall, 0);
    chk("r40_load_a", mem_a, 32'h100);
    drv_ld(1'b0, 32'h0, 3'b100);
    #1;
    chk("r40_d1", mem_a, 32'h44);
    tick();
    chk("r40_d2", mem_a, 32'h48);
    tick();
    chk("r40_d3", mem_a, 32'h4C);
    tick();
    chk("r40_empty", empty, 1);

    // Byte store at 0x21 blocks a word load at 0x20 until drained.
    drv_st(1'b1, 32'h21, 32'h77, 2'b10);
    drv_ld(1'b1, 32'h100, 3'b100);
    tick();
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    drv_ld(1'b1, 32'h20, 3'b100);
    #1;
    chk("r38_stall", ld_stall, 1);
    chk("r38_a", mem_a, 32'h21);
    chk("r38_wc", 32'(mem_writecontrol), 32'h2);
    tick();
    chk("r38_stall2", ld_stall, 0);
    chk("r38_we", mem_we, 0);
    chk("r38_a2", mem_a, 32'h20);

    // Half store at 0x24 does not cover a byte load at 0x26.
    drv_st(1'b1, 32'h24, 32'h1234, 2'b01);
    tick();
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    drv_ld(1'b1, 32'h26, 3'b000);
    #1;
    chk("r39_stall", ld_stall, 0);
    chk("r39_we", mem_we, 0);
    chk("r39_a", mem_a, 32'h26);
    chk("r39_rc", 32'(mem_readcontrol), 32'h0);
    tick();
    chk("r39_kept", empty, 0);
    drv_ld(1'b0, 32'h0, 3'b100);
    tick();
    tick();

    // Reset in the middle of a drain discards everything.
    drv_ld(1'b1, 32'h100, 3'b100);
    for (int k = 0; k < 3; k++) begin
      drv_st(1'b1, 32'h60 + 32'(4 * k), 32'hC0 + 32'(k), 2'b00);
      tick();
    end
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    drv_ld(1'b0, 32'h0, 3'b100);
    #1;
    chk("r41_we", mem_we, 1);
    chk("r41_a", mem_a, 32'h60);
    tick();
    reset = 1'b1;
    #1;
    chk("r41_rst_we", mem_we, 0);
    chk("r41_rst_empty", empty, 1);
    chk("r41_rst_ready", st_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r41_quiet", mem_we, 0);
    end

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      drv_st(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 2'($urandom_range(0, 3)));
      drv_ld(1'($urandom_range(0, 2) != 0), rnd_addr(), 3'($urandom_range(0, 7)));
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    drv_st(1'b0, 32'h0, 32'h0, 2'b00);
    drv_ld(1'b0, 32'h0, 3'b100);
    for (int k = 0; k < DEPTH + 2; k++) tick();
    chk("final_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..8).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 st_valid  in  1  MEM stage presents a store.
REQ-006 st_addr  in  32  byte address of store.
REQ-007 st_data  in  32  store data; low bytes used for half/byte.
REQ-008 st_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-009 st_ready  out  1  store accepted this cycle when st_valid high.
REQ-010 ld_valid  in  1  MEM stage presents a load.
REQ-011 ld_addr  in  32  byte address of load.
REQ-012 ld_size  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100/others lw.
REQ-013 ld_stall  out  1  load cannot be served this cycle; pipeline holds it.
REQ-014 mem_we  out  1  data-memory write enable.
REQ-015 mem_a  out  32  data-memory address (shared by read and write).
REQ-016 mem_wd  out  32  data-memory write data.
REQ-017 mem_writecontrol  out  2  store size to memory, st_size encoding.
REQ-018 mem_readcontrol  out  3  load size to memory, ld_size encoding.
REQ-019 empty  out  1  no buffered stores (used for fence/halt).

Function
REQ-020 SHALL hold up to DEPTH entries {addr, data, size} in FIFO order; head/tail pointers wrap modulo DEPTH.
REQ-021 SHALL drive st_ready = (count != DEPTH); push on posedge when st_valid && st_ready.
REQ-022 SHALL not bypass: a pushed store reaches memory no earlier than the next cycle.
REQ-023 Conflict = ld_valid and byte range [ld_addr, ld_addr+n-1] overlaps any valid entry range (n = 1/2/4 per size), computed in 33 bits so no wrap aliasing.
REQ-024 Mode LOAD (ld_valid, no conflict, count != DEPTH): mem_we=0, mem_a=ld_addr, mem_readcontrol=ld_size, ld_stall=0, no pop.
REQ-025 Mode DRAIN (count != 0 and not LOAD): mem_we=1, mem_a/mem_wd/mem_writecontrol from head; pop on posedge.
REQ-026 ld_stall SHALL be 1 whenever ld_valid and (conflict or count == DEPTH); drain proceeds that cycle.
REQ-027 Idle (count==0, no load): mem_we=0, mem_a=0, mem_readcontrol=100.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; full blocks push even if popping.
REQ-029 All outputs combinational from state and inputs; drain throughput one store per cycle.
REQ-030 empty = (count == 0).

Reset
REQ-031 Reset SHALL clear head, tail, count immediately; entry storage is not reset.
REQ-032 During reset: st_ready=1, empty=1, mem_we=0, ld_stall=0 unless ld_valid conflict impossible (always 0).
REQ-033 Reset mid-drain SHALL discard all buffered stores; no write issued after reset asserts.

Structure
REQ-034 Package cpu_mem_pkg SHALL hold writecontrol/readcontrol encodings and a size-to-byte-count function.
REQ-035 One sub-module sb_overlap (per-entry range-overlap compare) is natural; FIFO stays inline.

Verification
REQ-036 Store word 0x10 data 0xDEADBEEF, no loads -> mem_we=1 next cycle, mem_a=0x10, mem_wd=0xDEADBEEF, empty=1 after.
REQ-037 Push 4 stores back-to-back with ld_valid held (no conflict) -> 5th store sees st_ready=0; ld_stall=1 while full; drain resumes.
REQ-038 Buffered sb at 0x21, load lw 0x20 -> ld_stall=1 until entry drains, then ld_stall=0, mem_a=0x20, mem_we=0.
REQ-039 Buffered sh at 0x24, load lb 0x26 -> no conflict, ld_stall=0, load served, store stays buffered.
REQ-040 Full buffer, push and pop same cycle attempted -> push refused, count 4->3.
REQ-041 Assert reset with 3 entries mid-drain -> mem_we=0 at once, empty=1, no further writes after release.
